// File: rtl/key_expand128_if.sv
// key_expand128_if -- signal bundle between the AES-128 key schedule and
// its environment.
//
// Groups every key_expand128 signal except clk/rst:
//   start, key_in     : expansion request and 128-bit cipher key
//   busy, done        : activity flag and one-cycle completion pulse
//   rk_valid/rk_ready : round-key handshake, payload rk_data/rk_idx
//   rcon_addr/data    : registered rcon lookup stage (1-cycle read latency)
//   sbox_in/sbox_out  : external combinational 4-byte S-box bank
//
// Modports:
//   master : the key schedule (drives busy, done, rk_*, rcon_addr, sbox_in)
//   slave  : the surroundings (drives start, key_in, rk_ready, rcon_data,
//            sbox_out)

interface key_expand128_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         done;
  logic [3:0]   rcon_addr;
  logic [31:0]  rcon_data;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  modport master (
    input  start, key_in, rk_ready, rcon_data, sbox_out,
    output busy, rk_valid, rk_data, rk_idx, done, rcon_addr, sbox_in
  );

  modport slave (
    output start, key_in, rk_ready, rcon_data, sbox_out,
    input  busy, rk_valid, rk_data, rk_idx, done, rcon_addr, sbox_in
  );
endinterface

// File: rtl/key_expand128.sv
// key_expand128 -- iterative AES-128 key schedule.
//
// Expands a 128-bit cipher key into NUM_ROUNDS+1 round keys, one per
// rk_valid/rk_ready handshake. Round key 0 is the cipher key itself; each
// further key is computed in a single GEN cycle from the previous one using
// the external S-box bank and the rcon constant.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : key_expand128_if.master (start/key_in, busy, done, rk_* handshake,
//          rcon_addr/rcon_data, sbox_in/sbox_out)
//
// Parameter:
//   NUM_ROUNDS : index of the last round key generated, 1..10
//
// Build option:
//   KEYEXP_LOCAL_RCON_EN : when defined, rcon is produced locally by an xtime
//                          byte register and bus.rcon_data is ignored;
//                          rcon_addr is driven the same way in both builds.
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; the done pulse is shown in the first IDLE cycle
// OUT   | round key presented on rk_data/rk_idx, waiting for rk_ready
// GEN   | single cycle computing the next round key from the current one

module key_expand128 #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic            clk,
  input  logic            rst,
  key_expand128_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    GEN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t       state;
  state_t       state_next;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic [3:0]   rcon_ptr;
  logic         done_pulse;
  logic         load_key;
  logic         load_next;
  logic         done_next;

  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;
  logic [31:0]  rcon_word;
  logic [31:0]  t;
  logic [31:0]  n0;
  logic [31:0]  n1;
  logic [31:0]  n2;
  logic [31:0]  n3;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_key   = 1'b0;
    load_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle still belongs to the previous expansion, so a start
        // coinciding with it is dropped.
        if (bus.start && !done_pulse) begin
          load_key   = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (bus.rk_ready) begin
          if (round_idx == LAST_IDX) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = GEN;
          end
        end
      end
      GEN: begin
        load_next  = 1'b1;
        state_next = OUT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Round function
  // ---------------------------------------------------------------------
  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  // RotWord(w3) goes out every cycle; only the GEN-cycle result is used.
  assign bus.sbox_in = {w3[23:0], w3[31:24]};

  assign t  = bus.sbox_out ^ rcon_word;
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

`ifdef KEYEXP_LOCAL_RCON_EN
  logic [7:0]  rc;
  logic [31:0] unused_rcon_data;

  assign unused_rcon_data = bus.rcon_data;

  // rc always holds Rcon for the key being generated next: 01 on start,
  // multiplied by x in GF(2^8) after every GEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= 8'h01;
    end else if (load_key) begin
      rc <= 8'h01;
    end else if (load_next) begin
      rc <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  end

  assign rcon_word = {rc, 24'h000000};
`else
  // rcon_ptr is updated on entry to OUT, so the registered rcon stage has
  // sampled it by the time GEN follows and rcon_data = Rcon[round_idx].
  assign rcon_word = bus.rcon_data;
`endif

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key  <= '0;
      round_idx  <= '0;
      rcon_ptr   <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= done_next;
      if (load_key) begin
        round_key <= bus.key_in;
        round_idx <= '0;
        rcon_ptr  <= '0;
      end else if (load_next) begin
        round_key <= {n0, n1, n2, n3};
        round_idx <= round_idx + 4'd1;
        rcon_ptr  <= round_idx + 4'd1;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.rk_valid  = (state == OUT);
  assign bus.rk_data   = round_key;
  assign bus.rk_idx    = round_idx;
  assign bus.done      = done_pulse;
  assign bus.rcon_addr = rcon_ptr;

endmodule
